// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-operation sequencer: opcodes, FSM
// states and the layout of a buffered command word.
package reg_seq_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
   localparam logic [OP_W-1:0] OP_CLR  = 3'd1;
   localparam logic [OP_W-1:0] OP_LOAD = 3'd2;
   localparam logic [OP_W-1:0] OP_INC  = 3'd3;
   localparam logic [OP_W-1:0] OP_DEC  = 3'd4;
   localparam logic [OP_W-1:0] OP_SHR  = 3'd5;
   localparam logic [OP_W-1:0] OP_SHL  = 3'd6;
   localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_e;

   // Command word layout, MSB to LSB: {op, data, rpt, fill}.
   function automatic int cmd_width(input int data_w, input int cnt_w);
      return OP_W + data_w + cnt_w + 1;
   endfunction

   // Opcodes that are accepted but produce no register operation.
   function automatic logic is_drop_op(input logic [OP_W-1:0] op);
      return (op == OP_NOP) || (op == OP_RSVD);
   endfunction

   // Opcodes whose strobe is repeated rpt times.
   function automatic logic is_rpt_op(input logic [OP_W-1:0] op);
      return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHR) || (op == OP_SHL);
   endfunction

endpackage

// File: rtl/reg_op_sequencer_if.sv
// Command valid/ready bus feeding the sequencer's command FIFO.
interface reg_op_sequencer_if #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 4
);
   import reg_seq_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [OP_W-1:0]   cmd_op;
   logic [DATA_W-1:0] cmd_data;
   logic [CNT_W-1:0]  cmd_rpt;
   logic              cmd_fill;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_rpt, cmd_fill,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_rpt, cmd_fill,
      output cmd_ready
   );

endinterface

// File: rtl/reg_op_sequencer_sync_fifo.sv
// Small first-word-fall-through FIFO with synchronous reset and flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // Qualify push/pop against the flags and compute next pointers; flush wins.
   always_comb begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = {(AW+1){1'b0}};
         rd_ptr_d = {(AW+1){1'b0}};
      end else begin
         do_push_s = push_i && !full_o;
         do_pop_s  = pop_i && !empty_o;
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/reg_op_sequencer.sv
// Command sequencer in front of the 4-bit control register. Buffered commands
// are expanded into one registered control strobe per clock; a command's last
// strobe pops the next command in the same cycle so repeats run back to back.
module reg_op_sequencer
   import reg_seq_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   reg_op_sequencer_if.slave cmd_if,
   input  logic              abort,
   output logic              cl,
   output logic              ld,
   output logic              inc,
   output logic              dec,
   output logic              sr,
   output logic              sl,
   output logic              ir,
   output logic              il,
   output logic [DATA_W-1:0] reg_in,
   output logic              busy,
   output logic              done
);

   localparam int CMD_W = cmd_width(DATA_W, CNT_W);

   logic [CMD_W-1:0]  push_word_s, head_word_s;
   logic              full_s, empty_s, push_s, pop_s, take_s;
   logic [OP_W-1:0]   head_op_s;
   logic [DATA_W-1:0] head_data_s;
   logic [CNT_W-1:0]  head_rpt_s, head_rem_s;
   logic              head_fill_s;

   state_e            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              fill_q, fill_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic              cl_q, cl_d, ld_q, ld_d, inc_q, inc_d, dec_q, dec_d;
   logic              sr_q, sr_d, sl_q, sl_d, ir_q, ir_d, il_q, il_d;
   logic [DATA_W-1:0] reg_in_q, reg_in_d;
   logic              done_q, done_d;

   assign cmd_if.cmd_ready = !full_s;
   assign push_s      = cmd_if.cmd_valid && !full_s;
   assign push_word_s = {cmd_if.cmd_op, cmd_if.cmd_data, cmd_if.cmd_rpt, cmd_if.cmd_fill};

   assign head_op_s   = head_word_s[CMD_W-1 -: OP_W];
   assign head_data_s = head_word_s[CNT_W+1 +: DATA_W];
   assign head_rpt_s  = head_word_s[1 +: CNT_W];
   assign head_fill_s = head_word_s[0];

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (abort),
      .push_i  (push_s),
      .wdata_i (push_word_s),
      .pop_i   (pop_s),
      .rdata_o (head_word_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   // Number of strobes the head command will issue; rpt=0 still issues once.
   always_comb begin
      head_rem_s = CNT_W'(1);
      if (is_rpt_op(head_op_s) && (head_rpt_s != {CNT_W{1'b0}})) begin
         head_rem_s = head_rpt_s;
      end else begin
         head_rem_s = CNT_W'(1);
      end
   end

   // FSM next state, command pop and next strobe values; abort clears all.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      data_d   = data_q;
      fill_d   = fill_q;
      rem_d    = rem_q;
      take_s   = 1'b0;
      pop_s    = 1'b0;
      cl_d     = 1'b0;
      ld_d     = 1'b0;
      inc_d    = 1'b0;
      dec_d    = 1'b0;
      sr_d     = 1'b0;
      sl_d     = 1'b0;
      ir_d     = 1'b0;
      il_d     = 1'b0;
      reg_in_d = {DATA_W{1'b0}};
      done_d   = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
         rem_d   = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               take_s = !empty_s;
            end
            S_ISSUE: begin
               case (op_q)
                  OP_CLR:  cl_d  = 1'b1;
                  OP_LOAD: begin
                     ld_d     = 1'b1;
                     reg_in_d = data_q;
                  end
                  OP_INC:  inc_d = 1'b1;
                  OP_DEC:  dec_d = 1'b1;
                  OP_SHR:  begin
                     sr_d = 1'b1;
                     ir_d = fill_q;
                  end
                  OP_SHL:  begin
                     sl_d = 1'b1;
                     il_d = fill_q;
                  end
                  default: cl_d = 1'b0;
               endcase
               rem_d = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  done_d = 1'b1;
                  if (!empty_s) begin
                     take_s = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  done_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
         // Pop the head into the current-command registers; drop-ops idle.
         if (take_s) begin
            pop_s   = 1'b1;
            op_d    = head_op_s;
            data_d  = head_data_s;
            fill_d  = head_fill_s;
            rem_d   = head_rem_s;
            state_d = is_drop_op(head_op_s) ? S_IDLE : S_ISSUE;
         end else begin
            pop_s = 1'b0;
         end
      end
   end

   // State, current command and registered strobe outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= OP_NOP;
         data_q   <= {DATA_W{1'b0}};
         fill_q   <= 1'b0;
         rem_q    <= {CNT_W{1'b0}};
         cl_q     <= 1'b0;
         ld_q     <= 1'b0;
         inc_q    <= 1'b0;
         dec_q    <= 1'b0;
         sr_q     <= 1'b0;
         sl_q     <= 1'b0;
         ir_q     <= 1'b0;
         il_q     <= 1'b0;
         reg_in_q <= {DATA_W{1'b0}};
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         data_q   <= data_d;
         fill_q   <= fill_d;
         rem_q    <= rem_d;
         cl_q     <= cl_d;
         ld_q     <= ld_d;
         inc_q    <= inc_d;
         dec_q    <= dec_d;
         sr_q     <= sr_d;
         sl_q     <= sl_d;
         ir_q     <= ir_d;
         il_q     <= il_d;
         reg_in_q <= reg_in_d;
         done_q   <= done_d;
      end
   end

   assign cl     = cl_q;
   assign ld     = ld_q;
   assign inc    = inc_q;
   assign dec    = dec_q;
   assign sr     = sr_q;
   assign sl     = sl_q;
   assign ir     = ir_q;
   assign il     = il_q;
   assign reg_in = reg_in_q;
   assign done   = done_q;
   assign busy   = (state_q == S_ISSUE) || !empty_s;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench for reg_op_sequencer: table of single commands with
// exact per-cycle expectations, hand-written multi-cycle sequences, and a
// randomized run compared against a command-expansion reference model.
module tb_reg_op_sequencer;
   import reg_seq_pkg::*;

   localparam int DATA_W = 4;
   localparam int CNT_W  = 4;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rst, abort;
   logic cl, ld, inc, dec, sr, sl, ir, il, busy, done;
   logic [DATA_W-1:0] reg_in;
   logic [5:0] vec;

   int checks   = 0;
   int failures = 0;

   reg_op_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) cmd_bus ();

   reg_op_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .cmd_if(cmd_bus), .abort(abort),
      .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
      .ir(ir), .il(il), .reg_in(reg_in), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   assign vec = {cl, ld, inc, dec, sr, sl};

   typedef struct {
      logic [5:0] vec;
      logic [3:0] data;
      logic       fill;
      logic       done;
   } ev_t;

   ev_t obs_q[$];
   ev_t exp_q[$];

   typedef struct {
      logic [2:0] op;
      logic [3:0] data;
      logic [3:0] rpt;
      logic       fill;
      logic [5:0] exp_vec;
      int         exp_n;
      logic [3:0] exp_reg_in;
      logic       exp_ir;
      logic       exp_il;
   } tv_t;

   tv_t tbl[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [5:0] op_vec(input logic [2:0] op);
      case (op)
         3'd1:    return 6'b100000;
         3'd2:    return 6'b010000;
         3'd3:    return 6'b001000;
         3'd4:    return 6'b000100;
         3'd5:    return 6'b000010;
         3'd6:    return 6'b000001;
         default: return 6'b000000;
      endcase
   endfunction

   function automatic logic [11:0] pk(input ev_t e);
      return {e.vec, e.data, e.fill, e.done};
   endfunction

   // Reference model: one accepted command becomes its list of strobe events.
   task automatic expect_cmd(input logic [2:0] op, input logic [3:0] data,
                             input logic [3:0] rpt, input logic fill);
      int n;
      ev_t e;
      if (op == 3'd1 || op == 3'd2) n = 1;
      else if (op >= 3'd3 && op <= 3'd6) n = (rpt == 4'd0) ? 1 : int'(rpt);
      else n = 0;
      for (int i = 0; i < n; i++) begin
         e.vec  = op_vec(op);
         e.data = (op == 3'd2) ? data : 4'd0;
         e.fill = (op == 3'd5 || op == 3'd6) ? fill : 1'b0;
         e.done = (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   // Output monitor: invariants every cycle plus a log of issued strobes.
   always @(negedge clk) begin
      logic ok;
      if (!rst) begin
         ok = ($countones(vec) <= 1) && (!ir || sr) && (!il || sl) &&
              (ld || reg_in == 4'd0) && (!done || vec != 6'd0);
         check("invariant", {31'd0, ok}, 32'd1);
         if (vec != 6'd0) begin
            ev_t e;
            e.vec = vec; e.data = reg_in; e.fill = ir | il; e.done = done;
            obs_q.push_back(e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [2:0] op, input logic [3:0] data,
                           input logic [3:0] rpt, input logic fill, output int waited);
      waited = 0;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = op;
      cmd_bus.cmd_data  = data;
      cmd_bus.cmd_rpt   = rpt;
      cmd_bus.cmd_fill  = fill;
      while (!cmd_bus.cmd_ready && waited < 200) begin
         tick();
         waited++;
      end
      if (waited >= 200) check("push_timeout", 32'd1, 32'd0);
      tick();
      cmd_bus.cmd_valid = 1'b0;
      expect_cmd(op, data, rpt, fill);
   endtask

   task automatic wait_idle(input int limit);
      int w = 0;
      while (busy && w < limit) begin
         tick();
         w++;
      end
      check("idle_timeout", {31'd0, busy}, 32'd0);
      tick();
      tick();
   endtask

   // Compare the monitor log against the model's event list (order matters).
   task automatic compare_q(input string name);
      check({name, "_len"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         check(name, {20'd0, pk(obs_q[i])}, {20'd0, pk(exp_q[i])});
      obs_q.delete();
      exp_q.delete();
   endtask

   // Strict cycle-by-cycle check: expected events must appear with no gap.
   task automatic check_cycles(input string name);
      ev_t cur;
      foreach (exp_q[i]) begin
         cur.vec = vec; cur.data = reg_in; cur.fill = ir | il; cur.done = done;
         check(name, {20'd0, pk(cur)}, {20'd0, pk(exp_q[i])});
         tick();
      end
      check({name, "_tail"}, {25'd0, vec, done}, 32'd0);
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      int w;
      tbl[0]  = '{3'd2, 4'hA, 4'd7,  1'b0, 6'b010000, 1,  4'hA, 1'b0, 1'b0};
      tbl[1]  = '{3'd1, 4'h3, 4'd5,  1'b1, 6'b100000, 1,  4'h0, 1'b0, 1'b0};
      tbl[2]  = '{3'd3, 4'h0, 4'd3,  1'b0, 6'b001000, 3,  4'h0, 1'b0, 1'b0};
      tbl[3]  = '{3'd4, 4'h0, 4'd0,  1'b0, 6'b000100, 1,  4'h0, 1'b0, 1'b0};
      tbl[4]  = '{3'd5, 4'h0, 4'd2,  1'b1, 6'b000010, 2,  4'h0, 1'b1, 1'b0};
      tbl[5]  = '{3'd6, 4'h0, 4'd1,  1'b0, 6'b000001, 1,  4'h0, 1'b0, 1'b0};
      tbl[6]  = '{3'd6, 4'h0, 4'd2,  1'b1, 6'b000001, 2,  4'h0, 1'b0, 1'b1};
      tbl[7]  = '{3'd0, 4'hF, 4'd3,  1'b1, 6'b000000, 0,  4'h0, 1'b0, 1'b0};
      tbl[8]  = '{3'd7, 4'hF, 4'd3,  1'b1, 6'b000000, 0,  4'h0, 1'b0, 1'b0};
      tbl[9]  = '{3'd3, 4'h0, 4'd15, 1'b0, 6'b001000, 15, 4'h0, 1'b0, 1'b0};
      tbl[10] = '{3'd2, 4'h5, 4'd0,  1'b1, 6'b010000, 1,  4'h5, 1'b0, 1'b0};

      rst = 1'b1; abort = 1'b0;
      cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_op = 3'd0; cmd_bus.cmd_data = 4'd0;
      cmd_bus.cmd_rpt = 4'd0; cmd_bus.cmd_fill = 1'b0;
      tick(); tick(); tick();
      rst = 1'b0;
      check("reset_outputs", {19'd0, vec, ir, il, reg_in, busy, done}, 32'd0);
      check("reset_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);

      // Table: one command into an idle block; first strobe two edges after push.
      for (int t = 0; t < 11; t++) begin
         push_cmd(tbl[t].op, tbl[t].data, tbl[t].rpt, tbl[t].fill, w);
         tick();
         tick();
         for (int j = 0; j < tbl[t].exp_n; j++) begin
            check($sformatf("tbl%0d_vec", t), {26'd0, vec}, {26'd0, tbl[t].exp_vec});
            check($sformatf("tbl%0d_done", t), {31'd0, done}, {31'd0, j == tbl[t].exp_n - 1});
            check($sformatf("tbl%0d_busy", t), {31'd0, busy}, {31'd0, j < tbl[t].exp_n - 1});
            check($sformatf("tbl%0d_data", t), {26'd0, reg_in, ir, il},
                  {26'd0, tbl[t].exp_reg_in, tbl[t].exp_ir, tbl[t].exp_il});
            tick();
         end
         check($sformatf("tbl%0d_after", t), {24'd0, vec, done, busy}, 32'd0);
         exp_q.delete();
         obs_q.delete();
      end

      // INC x3 then DEC rpt=0 pushed back to back: no bubble between them.
      push_cmd(3'd3, 4'd0, 4'd3, 1'b0, w);
      push_cmd(3'd4, 4'd0, 4'd0, 1'b0, w);
      tick();
      check_cycles("inc_dec");

      // SHR x2 fill=1 then SHL x1 fill=0.
      push_cmd(3'd5, 4'd0, 4'd2, 1'b1, w);
      push_cmd(3'd6, 4'd0, 4'd1, 1'b0, w);
      tick();
      check_cycles("shr_shl");

      // Fill the FIFO while INC x15 runs; the fifth command must wait.
      push_cmd(3'd3, 4'd0, 4'd15, 1'b0, w);
      push_cmd(3'd1, 4'd0, 4'd0, 1'b0, w);
      push_cmd(3'd2, 4'd3, 4'd0, 1'b0, w);
      push_cmd(3'd3, 4'd0, 4'd1, 1'b0, w);
      push_cmd(3'd4, 4'd0, 4'd2, 1'b0, w);
      check("full_ready", {31'd0, cmd_bus.cmd_ready}, 32'd0);
      push_cmd(3'd6, 4'd0, 4'd1, 1'b1, w);
      check("full_wait", w, 32'd12);
      wait_idle(100);
      compare_q("full_order");

      // Abort during the 2nd DEC strobe with two queued and one same-cycle push.
      push_cmd(3'd4, 4'd0, 4'd5, 1'b0, w);
      push_cmd(3'd1, 4'd0, 4'd0, 1'b0, w);
      push_cmd(3'd2, 4'd9, 4'd0, 1'b0, w);
      tick();
      check("abort_pre", {26'd0, vec}, 32'b000100);
      abort = 1'b1;
      cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_op = 3'd1;
      tick();
      abort = 1'b0;
      cmd_bus.cmd_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check("abort_quiet", {23'd0, vec, done, busy, ~cmd_bus.cmd_ready, 1'b0}, 32'd0);
         tick();
      end
      check("abort_strobes", obs_q.size(), 32'd2);
      exp_q.delete();
      obs_q.delete();

      // NOP and reserved opcode between two CLRs.
      push_cmd(3'd1, 4'd0, 4'd0, 1'b0, w);
      push_cmd(3'd0, 4'd0, 4'd3, 1'b1, w);
      push_cmd(3'd7, 4'd0, 4'd3, 1'b1, w);
      push_cmd(3'd1, 4'd0, 4'd0, 1'b0, w);
      wait_idle(50);
      compare_q("nop_rsvd");

      // Reset in the middle of a repeated command drops the remainder.
      push_cmd(3'd3, 4'd0, 4'd6, 1'b0, w);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("rst_mid", {24'd0, vec, done, busy, ~cmd_bus.cmd_ready}, 32'd0);
         tick();
      end
      exp_q.delete();
      obs_q.delete();

      // Randomized command stream against the expansion model.
      for (int r = 0; r < 60; r++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) tick();
         push_cmd(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom), w);
      end
      wait_idle(600);
      compare_q("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
